// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with 2-entry skid buffer, MIPS field split, flush and stall counter.
module if_id_stage #(
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [31:0]            in_pc4,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [31:0]            out_pc4,
  output logic [5:0]             opcode,
  output logic [4:0]             rs,
  output logic [4:0]             rt,
  output logic [4:0]             rd,
  output logic [4:0]             shamt,
  output logic [5:0]             funct,
  output logic [15:0]            imm16,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  logic        main_valid, skid_valid;
  logic [31:0] main_instr, main_pc4, skid_instr, skid_pc4;
  logic        accept, release_w;
  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready;
  assign release_w = main_valid & out_ready;
  assign out_valid = main_valid;
  assign out_instr = main_instr;
  assign out_pc4   = main_pc4;
  assign opcode    = out_instr[31:26];
  assign rs        = out_instr[25:21];
  assign rt        = out_instr[20:16];
  assign rd        = out_instr[15:11];
  assign shamt     = out_instr[10:6];
  assign funct     = out_instr[5:0];
  assign imm16     = out_instr[15:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_instr <= RESET_INSTR;
      skid_instr <= RESET_INSTR;
      main_pc4   <= '0;
      skid_pc4   <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_instr <= RESET_INSTR;
      skid_instr <= RESET_INSTR;
    end else if (!main_valid || release_w) begin
      // skid only holds a word while main is full, so it always drains first
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_instr <= skid_instr;
        main_pc4   <= skid_pc4;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_instr <= in_instr;
        main_pc4   <= in_pc4;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_instr <= in_instr;
      skid_pc4   <= in_pc4;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (main_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Pipeline register between instruction fetch and decode.
- Captures the fetched instruction word and PC+4 behind a valid/ready handshake, using a 2-entry skid buffer so upstream never sees combinational ready paths.
- Splits the held instruction into MIPS fields. The imm16 output feeds the sign-extension unit; rs/rt/rd feed the register file.
- Supports pipeline flush on taken branch/jump and counts back-pressure cycles for debug.

Parameters:
- RESET_INSTR, 32'h0000_0000, instruction value held in data registers after reset/flush (MIPS NOP).
- STALL_CNT_W, 16, width of saturating back-pressure counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch presents a word.
- in_ready  output  1  stage can accept; equals NOT skid_valid (registered state only).
- in_instr  input  32  fetched instruction.
- in_pc4  input  32  PC+4 of fetched instruction.
- flush  input  1  discard all held and incoming words.
- out_valid  output  1  decode-side word valid.
- out_ready  input  1  decode accepts word.
- out_instr  output  32  held instruction.
- out_pc4  output  32  held PC+4.
- opcode  output  6  out_instr[31:26].
- rs  output  5  out_instr[25:21].
- rt  output  5  out_instr[20:16].
- rd  output  5  out_instr[15:11].
- shamt  output  5  out_instr[10:6].
- funct  output  6  out_instr[5:0].
- imm16  output  16  out_instr[15:0], unextended.
- stall_cnt  output  STALL_CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- State: main entry {main_valid, main_instr, main_pc4}; skid entry {skid_valid, skid_instr, skid_pc4}.
- Outputs: out_valid=main_valid; out_instr/out_pc4 come from main; field outputs are combinational slices of out_instr.
- Reset (rst=1 at edge): main_valid=0, skid_valid=0, instr regs=RESET_INSTR, pc4 regs=0, stall_cnt=0. Next cycle in_ready=1, out_valid=0, opcode..imm16 all 0.
- Accept = in_valid & in_ready. Release = out_valid & out_ready.
- Latency: an accepted word appears on out_* the cycle after acceptance when main is empty or being released.
- State cases, per edge with no flush:
  - main empty, accept: word goes to main.
  - main full, release, no accept: skid moves to main if skid_valid; otherwise main_valid=0.
  - main full, release and accept: if skid_valid=0, the new word goes to main. (skid_valid=1 implies in_ready=0, so accept is impossible.)
  - main full, no release, accept: word goes to skid; skid_valid=1; in_ready=0 next cycle.
  - main full and skid full, no release: hold; in_ready=0.
- Ordering: words leave in acceptance order. No word is dropped or duplicated.
- flush=1 at edge:
  - main_valid=0, skid_valid=0; instr regs=RESET_INSTR.
  - A word accepted in the same cycle is discarded.
  - A simultaneous release still counts as consumed downstream.
  - Flush has priority over everything except rst.
- stall_cnt: +1 each edge with out_valid & ~out_ready; saturates at all-ones; never wraps. Cleared only by rst, not by flush.
- Data registers load only on the enables above. They do not change while holding.
- rst asserted mid-stream: identical to power-up reset regardless of occupancy. Held words are lost.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, in_ready=1 after release, stall_cnt=0, imm16=0.
- I-type: push 32'h2008_2710 with pc4=32'h0000_0004, out_ready=1 -> next cycle out_valid=1, opcode=6'h08, rs=0, rt=8, imm16=16'h2710, out_pc4=4.
- Negative immediate plus R-type, back-to-back: 32'h8D09_FFFC then 32'h012A_5820 -> first opcode=6'h23, rs=8, rt=9, imm16=16'hFFFC. Second opcode=0, rs=9, rt=10, rd=11, shamt=0, funct=6'h20. Throughput 1/cycle.
- Back-pressure: out_ready=0, push 3 words A, B, C -> A in main, B in skid, in_ready=0, C not accepted. Hold 5 cycles -> stall_cnt=5. Raise out_ready -> A, B, C delivered in order.
- Flush with both entries full while a word is offered -> next cycle out_valid=0, in_ready=1, out_instr=RESET_INSTR. The offered word never appears; stall_cnt unchanged.
- Saturation: STALL_CNT_W=4, stall 20 cycles -> stall_cnt=4'hF. rst -> 0.
